// File: rtl/instr_exec_unit_if.sv
// Fetch bus and result handshake between instr_exec_unit and its neighbours.
// The exec unit is the master: it drives the read address and the result stream.
interface instr_exec_unit_if #(
    parameter int ADDR_W = 5,
    parameter int OP_W   = 32,
    parameter int RES_W  = 64
);
    logic [ADDR_W-1:0]   read_pointer;
    logic [4+2*OP_W-1:0] instr_word;
    logic                result_valid;
    logic                result_ready;
    logic [RES_W-1:0]    result;
    logic [3:0]          result_opcode;
    logic [ADDR_W-1:0]   result_addr;
    logic                err;

    modport master (
        output read_pointer,
        input  instr_word,
        output result_valid,
        input  result_ready,
        output result,
        output result_opcode,
        output result_addr,
        output err
    );

    modport slave (
        input  read_pointer,
        output instr_word,
        input  result_valid,
        output result_ready,
        input  result,
        input  result_opcode,
        input  result_addr,
        input  err
    );
endinterface

// File: rtl/instr_exec_unit.sv
// Fetches a run of instruction words, executes each one and streams results out.
// Optional stall counter output enabled by defining EXEC_STALL_CNT_EN.
module instr_exec_unit #(
    parameter int ADDR_W = 5,
    parameter int OP_W   = 32,
    parameter int RES_W  = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   num_instr,
    instr_exec_unit_if.master bus,
    output logic              busy,
    output logic              done
`ifdef EXEC_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cycles
`endif
);

    localparam int W = 4 + 2*OP_W;

    localparam logic [3:0] OP_ZERO  = 4'd0;
    localparam logic [3:0] OP_PASSA = 4'd1;
    localparam logic [3:0] OP_PASSB = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_MULT  = 4'd5;
    localparam logic [3:0] OP_DIV   = 4'd6;
    localparam logic [3:0] OP_MOD   = 4'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_OUT,
        S_DONE
    } state_e;

    state_e state, state_nxt;

    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W:0]   remaining;
    logic [W-1:0]      word_q;
    logic [RES_W-1:0]  result_q;
    logic [3:0]        opcode_q;
    logic [ADDR_W-1:0] addr_q;
    logic              err_q;

    logic                    run_accept;
    logic                    result_accept;
    logic [3:0]              exe_op;
    logic signed [OP_W-1:0]  op_a;
    logic signed [OP_W-1:0]  op_b;
    logic signed [RES_W-1:0] a_ext;
    logic signed [RES_W-1:0] b_ext;
    logic signed [RES_W-1:0] exe_res;
    logic                    exe_err;

    assign run_accept    = (state == S_IDLE) && start;
    assign result_accept = (state == S_OUT) && bus.result_ready;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (num_instr == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: state_nxt = S_EXEC;
            S_EXEC:  state_nxt = S_OUT;
            S_OUT: begin
                if (bus.result_ready) begin
                    // remaining still holds the pre-decrement count here
                    state_nxt = (remaining == (ADDR_W+1)'(1)) ? S_DONE : S_FETCH;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Run bookkeeping: pointer wraps naturally at 2**ADDR_W.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr       <= '0;
            remaining <= '0;
        end else if (run_accept && (num_instr != '0)) begin
            ptr       <= start_addr;
            remaining <= num_instr;
        end else if (result_accept) begin
            ptr       <= ptr + ADDR_W'(1);
            remaining <= remaining - (ADDR_W+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_q <= '0;
        end else if (state == S_FETCH) begin
            word_q <= bus.instr_word;
        end
    end

    // Datapath: operands are sign-extended to the result width before any
    // arithmetic, so the product and quotients cannot overflow.
    assign exe_op = word_q[W-1 -: 4];
    assign op_a   = word_q[2*OP_W-1:OP_W];
    assign op_b   = word_q[OP_W-1:0];
    assign a_ext  = {{(RES_W-OP_W){op_a[OP_W-1]}}, op_a};
    assign b_ext  = {{(RES_W-OP_W){op_b[OP_W-1]}}, op_b};

    always_comb begin
        exe_res = '0;
        exe_err = 1'b0;
        case (exe_op)
            OP_ZERO:  exe_res = '0;
            OP_PASSA: exe_res = a_ext;
            OP_PASSB: exe_res = b_ext;
            OP_ADD:   exe_res = a_ext + b_ext;
            OP_SUB:   exe_res = a_ext - b_ext;
            OP_MULT:  exe_res = a_ext * b_ext;
            OP_DIV: begin
                if (b_ext == '0) exe_err = 1'b1;
                else             exe_res = a_ext / b_ext;
            end
            OP_MOD: begin
                if (b_ext == '0) exe_err = 1'b1;
                else             exe_res = a_ext % b_ext;
            end
            default:  exe_err = 1'b1;
        endcase
    end

    // Result registers hold steady through OUT until accepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result_q <= '0;
            err_q    <= 1'b0;
            opcode_q <= '0;
            addr_q   <= '0;
        end else if (state == S_EXEC) begin
            result_q <= exe_res;
            err_q    <= exe_err;
            opcode_q <= exe_op;
            addr_q   <= ptr;
        end
    end

`ifdef EXEC_STALL_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles <= '0;
        end else if (run_accept) begin
            stall_cycles <= '0;
        end else if ((state == S_OUT) && !bus.result_ready && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end
`endif

    assign bus.read_pointer  = ptr;
    assign bus.result_valid  = (state == S_OUT);
    assign bus.result        = result_q;
    assign bus.err           = err_q;
    assign bus.result_opcode = opcode_q;
    assign bus.result_addr   = addr_q;
    assign busy              = (state != S_IDLE);
    assign done              = (state == S_DONE);

endmodule

// File: tb/tb_instr_exec_unit.sv
// Self-checking bench for instr_exec_unit: directed scenarios plus random runs
// checked against a longint arithmetic reference model.
module tb_instr_exec_unit;

    localparam int ADDR_W = 5;
    localparam int OP_W   = 32;
    localparam int RES_W  = 64;
    localparam int W      = 4 + 2*OP_W;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] start_addr = '0;
    logic [ADDR_W:0]   num_instr = '0;
    logic              ready = 1'b0;
    logic              busy;
    logic              done;
`ifdef EXEC_STALL_CNT_EN
    logic [15:0]       stall_cycles;
`endif

    logic [W-1:0] mem [32];

    int checks   = 0;
    int failures = 0;

    instr_exec_unit_if #(.ADDR_W(ADDR_W), .OP_W(OP_W), .RES_W(RES_W)) bus ();

    assign bus.instr_word   = mem[bus.read_pointer];
    assign bus.result_ready = ready;

    instr_exec_unit #(.ADDR_W(ADDR_W), .OP_W(OP_W), .RES_W(RES_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .start_addr (start_addr),
        .num_instr  (num_instr),
        .bus        (bus.master),
        .busy       (busy),
        .done       (done)
`ifdef EXEC_STALL_CNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] mk(input int op, input int a, input int b);
        logic [3:0] o;
        o = op[3:0];
        return {o, a, b};
    endfunction

    // Reference: interpret the word directly from the opcode table.
    function automatic void ref_exec(input logic [W-1:0] w, output longint res, output bit e);
        int     op;
        longint a;
        longint b;
        op  = int'(w[W-1 -: 4]);
        a   = longint'(signed'(w[63:32]));
        b   = longint'(signed'(w[31:0]));
        res = 0;
        e   = 1'b0;
        if (op > 7 || ((op == 6 || op == 7) && b == 0)) e = 1'b1;
        else if (op == 1) res = a;
        else if (op == 2) res = b;
        else if (op == 3) res = a + b;
        else if (op == 4) res = a - b;
        else if (op == 5) res = a * b;
        else if (op == 6) res = a / b;
        else if (op == 7) res = a % b;
    endfunction

    function automatic logic [W-1:0] rand_word();
        int op;
        int a;
        int b;
        op = ($urandom_range(3, 0) == 0) ? int'($urandom_range(15, 8)) : int'($urandom_range(7, 0));
        a  = ($urandom_range(1, 0) == 1) ? int'($urandom) : int'($urandom_range(40, 0)) - 20;
        b  = ($urandom_range(7, 0) == 0) ? 0 : (($urandom_range(1, 0) == 1) ? int'($urandom) : int'($urandom_range(40, 0)) - 20);
        return mk(op, a, b);
    endfunction

    // One run: tied=1 keeps result_ready high; otherwise each result is
    // stalled stall_min..stall_max cycles with stray start pulses meanwhile.
    task automatic do_run(input int sa, input int n, input bit tied, input int stall_min, input int stall_max);
        int        cyc;
        int        s;
        int        addr;
        int        stall_run;
        longint    er;
        bit        ee;
        logic [63:0] held_res;
        stall_run = 0;
        @(negedge clk);
        start = 1'b1; start_addr = ADDR_W'(sa); num_instr = (ADDR_W+1)'(n); ready = tied;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        if (n == 0) begin
            // an empty run goes straight from IDLE to DONE
            check("empty_done", done, 1'b1);
            check("empty_no_valid", bus.result_valid, 1'b0);
            @(negedge clk);
            check("empty_done_clear", done, 1'b0);
            check("empty_idle", busy, 1'b0);
            check("empty_no_valid2", bus.result_valid, 1'b0);
        end else begin
            for (int i = 0; i < n; i++) begin
                addr = (sa + i) % 32;
                while (!bus.result_valid && cyc < 12) begin
                    @(negedge clk);
                    cyc++;
                end
                check("valid_seen", bus.result_valid, 1'b1);
                check("latency", cyc, 3);
                ref_exec(mem[addr], er, ee);
                check("result", bus.result, er);
                check("err", bus.err, ee);
                check("opcode", bus.result_opcode, mem[addr][W-1 -: 4]);
                check("result_addr", bus.result_addr, addr);
                check("read_pointer", bus.read_pointer, addr);
                check("busy_run", busy, 1'b1);
                if (!tied) begin
                    s = int'($urandom_range(stall_max, stall_min));
                    held_res = bus.result;
                    for (int k = 0; k < s; k++) begin
                        start = $urandom_range(1, 0);
                        @(negedge clk);
                        check("hold_valid", bus.result_valid, 1'b1);
                        check("hold_result", bus.result, held_res);
                        check("hold_addr", bus.result_addr, addr);
                    end
                    stall_run += s;
                    start = 1'b0;
                    ready = 1'b1;
                end
                @(negedge clk);
                ready = tied;
                cyc = 1;
                check("valid_drop", bus.result_valid, 1'b0);
                check("done_timing", done, (i == n - 1));
            end
            @(negedge clk);
            check("done_pulse_end", done, 1'b0);
            check("idle_after_run", busy, 1'b0);
        end
`ifdef EXEC_STALL_CNT_EN
        check("stall_cycles", stall_cycles, stall_run);
`endif
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = '0;

        // Reset state
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", bus.result_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_rp", bus.read_pointer, 0);
        check("rst_result", bus.result, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Mixed run with result_ready tied high
        mem[0] = mk(3, 5, -7);
        mem[1] = mk(4, 3, 10);
        mem[2] = mk(5, -65536, 65536);
        mem[3] = mk(2, 1, -1);
        do_run(0, 4, 1'b1, 0, 0);

        // Error cases and signed division corners
        mem[8]  = mk(6, 7, 0);
        mem[9]  = mk(7, -7, 3);
        mem[10] = mk(12, 4, 4);
        mem[11] = mk(6, -7, 2);
        mem[12] = mk(7, 9, 0);
        mem[13] = mk(6, 32'h8000_0000, -1);
        mem[14] = mk(5, 32'h8000_0000, 32'h8000_0000);
        mem[15] = mk(15, -1, -1);
        do_run(8, 8, 1'b0, 0, 2);

        // Pointer wrap 30,31,0,1 and an empty run
        mem[30] = rand_word(); mem[31] = rand_word();
        mem[0]  = rand_word(); mem[1]  = rand_word();
        do_run(30, 4, 1'b0, 0, 3);
        do_run(5, 0, 1'b0, 0, 0);

        // Backpressure of exactly 5 cycles
        mem[20] = mk(3, 100, 23);
        do_run(20, 1, 1'b0, 5, 5);

        // Asynchronous reset while a result is waiting in OUT
        mem[4] = mk(1, 77, 0);
        mem[5] = mk(1, 78, 0);
        @(negedge clk);
        start = 1'b1; start_addr = 5'd4; num_instr = 6'd2; ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_rst_valid", bus.result_valid, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_valid", bus.result_valid, 1'b0);
        check("arst_result", bus.result, 0);
        check("arst_err", bus.err, 1'b0);
        check("arst_addr", bus.result_addr, 0);
        check("arst_opcode", bus.result_opcode, 0);
        check("arst_rp", bus.read_pointer, 0);
        check("arst_busy", busy, 1'b0);
        check("arst_done", done, 1'b0);
`ifdef EXEC_STALL_CNT_EN
        check("arst_stall", stall_cycles, 0);
`endif
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_busy", busy, 1'b0);
        check("post_rst_done", done, 1'b0);
        do_run(4, 2, 1'b1, 0, 0);

        // Random runs over a random register file
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 32; i++) mem[i] = rand_word();
            do_run(int'($urandom_range(31, 0)), int'($urandom_range(32, 1)),
                   bit'($urandom_range(1, 0)), 0, 3);
        end
        do_run(0, 32, 1'b1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
